counter_sched: RTL and testbench

Run-time-programmable sequencer for the counter datapath. It accepts a count command over a valid/ready handshake: start value, end value, step and number of passes. It then streams the resulting count values with ready backpressure and flags pass and command boundaries. It sits between a host/config bus and consumers that need counter sequences whose start, end and step are chosen at run time rather than fixed by parameters.

---
 rtl/counter_sched_if.sv | 29 ++
 rtl/counter_sched.sv | 164 ++++++++++++++++
 tb/tb_counter_sched.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_sched_if.sv
// Command and output-stream channels of the counter sequencer.
// The master modport is the host/consumer side; the slave modport is the sequencer.
interface counter_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int REP_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_from;
  logic [DATA_WIDTH-1:0] cmd_to;
  logic [DATA_WIDTH-1:0] cmd_step;
  logic [REP_WIDTH-1:0]  cmd_reps;
  logic                  abort;
  logic [DATA_WIDTH-1:0] out;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  out_final;

  modport master (
    output cmd_valid, cmd_from, cmd_to, cmd_step, cmd_reps, abort, out_ready,
    input  cmd_ready, out, out_valid, out_last, out_final
  );

  modport slave (
    input  cmd_valid, cmd_from, cmd_to, cmd_step, cmd_reps, abort, out_ready,
    output cmd_ready, out, out_valid, out_last, out_final
  );
endinterface

// File: rtl/counter_sched.sv
// Run-time-programmable counter sequencer: accepts a from/to/step/reps command
// and streams the count values with backpressure, flagging pass and command ends.
module counter_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int REP_WIDTH  = 8
) (
  input  logic           clk,
  input  logic           rst,
  counter_sched_if.slave bus,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  out_final_q, out_final_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] from_q, from_d;
  logic [DATA_WIDTH-1:0] to_q, to_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [REP_WIDTH-1:0]  reps_q, reps_d;
  logic [REP_WIDTH-1:0]  pass_q, pass_d;

  logic [DATA_WIDTH:0]   nxt;
  logic                  hs;
  logic [REP_WIDTH-1:0]  pass_inc;

  // Last-of-pass is evaluated for the value being loaded so the flag is registered with it.
  function automatic logic is_last(input logic [DATA_WIDTH-1:0] v,
                                   input logic [DATA_WIDTH-1:0] s,
                                   input logic [DATA_WIDTH-1:0] t);
    logic [DATA_WIDTH:0] n;
    n = {1'b0, v} + {1'b0, s};
    return n[DATA_WIDTH] || (n > {1'b0, t});
  endfunction

  function automatic logic is_final(input logic                 last,
                                    input logic [REP_WIDTH-1:0] reps,
                                    input logic [REP_WIDTH-1:0] pass);
    return last && (reps != '0) && (pass == reps);
  endfunction

  assign nxt      = {1'b0, out_q} + {1'b0, step_q};
  assign hs       = out_valid_q && bus.out_ready;
  assign pass_inc = pass_q + REP_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_final_d = out_final_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    from_d      = from_q;
    to_d        = to_q;
    step_d      = step_q;
    reps_d      = reps_q;
    pass_d      = pass_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if ((bus.cmd_step == '0) || (bus.cmd_from > bus.cmd_to)) begin
            err_d = 1'b1;
          end else begin
            from_d      = bus.cmd_from;
            to_d        = bus.cmd_to;
            step_d      = bus.cmd_step;
            reps_d      = bus.cmd_reps;
            pass_d      = REP_WIDTH'(1);
            out_d       = bus.cmd_from;
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
            out_last_d  = is_last(bus.cmd_from, bus.cmd_step, bus.cmd_to);
            out_final_d = is_final(out_last_d, bus.cmd_reps, REP_WIDTH'(1));
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        if (hs && out_final_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          out_final_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end else if (bus.abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          out_final_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else if (hs) begin
          if (!out_last_q) begin
            out_d       = nxt[DATA_WIDTH-1:0];
            out_last_d  = is_last(nxt[DATA_WIDTH-1:0], step_q, to_q);
            out_final_d = is_final(out_last_d, reps_q, pass_q);
          end else begin
            // Endless mode never consults the pass count, so it is left frozen.
            if (reps_q != '0) begin
              pass_d = pass_inc;
            end
            out_d       = from_q;
            out_last_d  = is_last(from_q, step_q, to_q);
            out_final_d = is_final(out_last_d, reps_q, pass_d);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_final_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      from_q      <= '0;
      to_q        <= '0;
      step_q      <= '0;
      reps_q      <= '0;
      pass_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_final_q <= out_final_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      from_q      <= from_d;
      to_q        <= to_d;
      step_q      <= step_d;
      reps_q      <= reps_d;
      pass_q      <= pass_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_final = out_final_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_counter_sched.sv
// Randomized self-checking bench for counter_sched against a list-based reference
// of the expected count stream (values per pass, pass ends, command end).
module tb_counter_sched;
  localparam int DW = 8;
  localparam int RW = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy, done, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int v;
    bit last;
    bit fin;
  } beat_t;

  beat_t exp_q[$];

  counter_sched_if #(.DATA_WIDTH(DW), .REP_WIDTH(RW)) bus ();

  counter_sched #(.DATA_WIDTH(DW), .REP_WIDTH(RW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream: each pass counts from..to by step; endless commands get
  // whole passes appended until at least min_beats are available.
  task automatic build(input int from, input int to, input int step,
                       input int reps, input int min_beats);
    int p;
    beat_t b;
    exp_q.delete();
    p = 1;
    while ((reps != 0 && p <= reps) || (reps == 0 && exp_q.size() < min_beats)) begin
      for (int v = from; v <= to; v += step) begin
        b.v    = v;
        b.last = (v + step > to);
        b.fin  = b.last && (reps != 0) && (p == reps);
        exp_q.push_back(b);
      end
      p++;
    end
  endtask

  task automatic run_cmd(input int from, input int to, input int step, input int reps,
                         input bit rnd, input int abort_at);
    int n, idx, cyc, budget;
    bit rdy, want_done;
    build(from, to, step, reps, abort_at);
    n      = (abort_at > 0) ? abort_at : exp_q.size();
    budget = n * 30 + 20;
    bus.cmd_valid = 1'b1;
    bus.cmd_from  = DW'(from);
    bus.cmd_to    = DW'(to);
    bus.cmd_step  = DW'(step);
    bus.cmd_reps  = RW'(reps);
    check("cmd_ready_idle", int'(bus.cmd_ready), 1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_from  = DW'($urandom);
    bus.cmd_to    = DW'($urandom);
    bus.cmd_step  = DW'($urandom);
    bus.cmd_reps  = RW'($urandom);
    check("done_low_after_accept", int'(done), 0);
    check("err_low_after_accept", int'(err), 0);
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < budget) begin
      check("out_valid", int'(bus.out_valid), 1);
      check("busy", int'(busy), 1);
      check("cmd_ready_run", int'(bus.cmd_ready), 0);
      check("out", int'(bus.out), exp_q[idx].v);
      check("out_last", int'(bus.out_last), int'(exp_q[idx].last));
      check("out_final", int'(bus.out_final), int'(exp_q[idx].fin));
      rdy = rnd ? 1'($urandom % 2) : 1'b1;
      if (abort_at > 0 && idx == n - 1) rdy = 1'b1;
      bus.out_ready = rdy;
      bus.abort     = (abort_at > 0) && (idx == n - 1);
      tick();
      bus.abort = 1'b0;
      if (rdy) idx++;
      cyc++;
    end
    if (idx < n) check("stream_timeout", idx, n);
    bus.out_ready = 1'b0;
    want_done = (abort_at == 0) || exp_q[n-1].fin;
    check("done_pulse", int'(done), int'(want_done));
    check("out_valid_end", int'(bus.out_valid), 0);
    check("busy_end", int'(busy), 0);
    check("cmd_ready_end", int'(bus.cmd_ready), 1);
    check("err_end", int'(err), 0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_from  = '0;
    bus.cmd_to    = '0;
    bus.cmd_step  = '0;
    bus.cmd_reps  = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_out", int'(bus.out), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_out_final", int'(bus.out_final), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    tick();
    check("rst_cmd_ready", int'(bus.cmd_ready), 1);

    // Abort while idle must be ignored.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("idle_abort_ready", int'(bus.cmd_ready), 1);
    check("idle_abort_valid", int'(bus.out_valid), 0);

    run_cmd(20, 25, 1, 1, 1'b0, 0);
    run_cmd(250, 255, 4, 3, 1'b0, 0);
    run_cmd(0, 255, 1, 2, 1'b0, 0);
    run_cmd(20, 25, 1, 1, 1'b1, 0);
    run_cmd(7, 7, 1, 2, 1'b1, 0);

    // Rejected commands back to back, then a valid one on the following edge.
    bus.cmd_valid = 1'b1;
    bus.cmd_from  = DW'(1);
    bus.cmd_to    = DW'(5);
    bus.cmd_step  = DW'(0);
    bus.cmd_reps  = RW'(1);
    tick();
    check("err_step0", int'(err), 1);
    check("rej_valid_a", int'(bus.out_valid), 0);
    check("rej_ready_a", int'(bus.cmd_ready), 1);
    bus.cmd_from = DW'(30);
    bus.cmd_to   = DW'(20);
    bus.cmd_step = DW'(1);
    tick();
    check("err_from_gt_to", int'(err), 1);
    check("rej_valid_b", int'(bus.out_valid), 0);
    check("rej_ready_b", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b0;
    run_cmd(3, 9, 2, 2, 1'b1, 0);

    run_cmd(5, 7, 1, 0, 1'b0, 10);
    run_cmd(5, 7, 1, 1, 1'b1, 3);

    for (int i = 0; i < 8; i++) begin
      int f, t, s, r;
      f = $urandom_range(0, 255);
      t = $urandom_range(f, 255);
      s = $urandom_range(1, 40);
      r = $urandom_range(1, 3);
      run_cmd(f, t, s, r, 1'b1, 0);
    end

    // Reset in the middle of a pass, then reissue the same command.
    bus.cmd_valid = 1'b1;
    bus.cmd_from  = DW'(100);
    bus.cmd_to    = DW'(200);
    bus.cmd_step  = DW'(3);
    bus.cmd_reps  = RW'(1);
    bus.out_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_out", int'(bus.out), 100 + 3 * 4);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_out", int'(bus.out), 0);
    check("async_rst_valid", int'(bus.out_valid), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_last", int'(bus.out_last), 0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("post_rst_ready", int'(bus.cmd_ready), 1);
    check("post_rst_valid", int'(bus.out_valid), 0);
    run_cmd(100, 200, 3, 1, 1'b1, 0);
    tick();
    check("done_one_cycle", int'(done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
